parity_serial_tx: RTL and testbench

Transmit side of the team's serial parity link. Accepts a parallel data word over a valid/ready handshake and shifts it out LSB-first, one bit per clock. Appends one parity bit per frame. The serial stream feeds the team's bit-serial parity checker. With even parity selected, the checker's running-parity state is back at "even" after every complete frame.

---
 rtl/parity_link_pkg.sv | 13 +
 rtl/parity_serial_tx.sv | 111 +++++++++++
 tb/tb_parity_serial_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/parity_link_pkg.sv
// Constants shared by the serial parity transmitter and the bit-serial parity checker.
package parity_link_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/parity_serial_tx.sv
// Serial parity transmitter: takes a word over valid/ready, sends it LSB-first,
// then one parity bit; a word offered during the parity cycle starts the next frame gap-free.
module parity_serial_tx
    import parity_link_pkg::*;
#(
    parameter int   DATA_W     = DEFAULT_DATA_W,
    parameter logic ODD_PARITY = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_first_q, ser_first_d;
    logic              ser_last_q, ser_last_d;
    logic              busy_q, busy_d;
    logic              accept;

    assign din_ready = (state_q == ST_IDLE) || (state_q == ST_PARITY);
    assign accept    = din_valid && din_ready;

    // Outputs are computed for the next cycle so every one of them comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        busy_d      = 1'b0;

        if (accept) begin
            state_d     = ST_SHIFT;
            shreg_d     = din;
            cnt_d       = '0;
            acc_d       = ODD_PARITY ^ din[0];
            ser_out_d   = din[0];
            ser_valid_d = 1'b1;
            ser_first_d = 1'b1;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // acc_q already covers every data bit of the frame here
                        state_d    = ST_PARITY;
                        ser_out_d  = acc_q;
                        ser_last_d = 1'b1;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        cnt_d     = cnt_q + 1'b1;
                        acc_d     = acc_q ^ shreg_q[1];
                        ser_out_d = shreg_q[1];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: even-parity and odd-parity instances, with a running-parity checker model.
module tb_parity_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, ser_out, ser_valid, ser_first, ser_last, busy;
    logic [7:0] din_o;
    logic       din_valid_o;
    logic       o_ready, o_out, o_valid, o_first, o_last, o_busy;
    logic       chk_par;

    int passed = 0;
    int total  = 0;

    parity_serial_tx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
    );

    parity_serial_tx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .din(din_o), .din_valid(din_valid_o),
        .din_ready(o_ready), .ser_out(o_out), .ser_valid(o_valid),
        .ser_first(o_first), .ser_last(o_last), .busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial even-parity checker fed by the even instance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_par <= 1'b0;
        else if (ser_valid) chk_par <= chk_par ^ ser_out;
    end

    task automatic test_reset();
        rst_n = 1'b0; din = 8'hA5; din_valid = 1'b1;
        din_o = 8'h00; din_valid_o = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if ({ser_valid, ser_out, busy, din_ready, ser_first, ser_last} !== 6'b000100)
                $display("FAIL reset_outputs got v=%b o=%b busy=%b rdy=%b f=%b l=%b want 0 0 0 1 0 0",
                         ser_valid, ser_out, busy, din_ready, ser_first, ser_last);
            else passed++;
        end
        din_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ser_valid, busy, din_ready, o_valid, o_ready} !== 5'b00101)
            $display("FAIL reset_release_idle got v=%b busy=%b rdy=%b ov=%b ordy=%b want 0 0 1 0 1",
                     ser_valid, busy, din_ready, o_valid, o_ready);
        else passed++;
    endtask

    task automatic test_single_frame(input logic [7:0] word, input logic exp_par, input string tag);
        logic exp_bit;
        din = word; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        din = ~word;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            exp_bit = (i < 8) ? word[i] : exp_par;
            total++;
            if (ser_out !== exp_bit)
                $display("FAIL %s_bit%0d ser_out=%b want %b", tag, i, ser_out, exp_bit);
            else passed++;
            total++;
            if ({ser_valid, ser_first, ser_last, busy, din_ready} !== {1'b1, i == 0, i == 8, 1'b1, i == 8})
                $display("FAIL %s_ctrl%0d v/f/l/busy/rdy=%b%b%b%b%b want %b%b%b%b%b", tag, i,
                         ser_valid, ser_first, ser_last, busy, din_ready,
                         1'b1, i == 0, i == 8, 1'b1, i == 8);
            else passed++;
        end
        @(posedge clk); #1;
        total++;
        if ({ser_valid, busy, din_ready, ser_last} !== 4'b0010)
            $display("FAIL %s_idle v/busy/rdy/last=%b%b%b%b want 0010", tag, ser_valid, busy, din_ready, ser_last);
        else passed++;
    endtask

    task automatic test_checker_even();
        test_single_frame(8'h07, 1'b1, "w07");
        total++;
        if (chk_par !== 1'b0)
            $display("FAIL checker_even chk_par=%b want 0", chk_par);
        else passed++;
    endtask

    task automatic test_odd_parity();
        logic exp_bit;
        din_o = 8'h00; din_valid_o = 1'b1;
        @(posedge clk); #1;
        din_valid_o = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            exp_bit = (i == 8);
            total++;
            if ({o_out, o_valid, o_first, o_last} !== {exp_bit, 1'b1, i == 0, i == 8})
                $display("FAIL odd_bit%0d out/v/f/l=%b%b%b%b want %b1%b%b", i,
                         o_out, o_valid, o_first, o_last, exp_bit, i == 0, i == 8);
            else passed++;
        end
        @(posedge clk); #1;
        total++;
        if ({o_valid, o_busy, o_ready} !== 3'b001)
            $display("FAIL odd_idle v/busy/rdy=%b%b%b want 001", o_valid, o_busy, o_ready);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_bits;
        int gaps;
        exp_bits = 18'b1_0000000_1_0_11111111;
        gaps = 0;
        din = 8'hFF; din_valid = 1'b1;
        @(posedge clk); #1;
        din = 8'h01;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i == 9) din_valid = 1'b0;
            if (!ser_valid) gaps++;
            total++;
            if (ser_out !== exp_bits[i])
                $display("FAIL b2b_bit%0d ser_out=%b want %b", i, ser_out, exp_bits[i]);
            else passed++;
            total++;
            if ({din_ready, ser_first, ser_last} !== {i == 8 || i == 17, i == 0 || i == 9, i == 8 || i == 17})
                $display("FAIL b2b_ctrl%0d rdy/f/l=%b%b%b want %b%b%b", i, din_ready, ser_first, ser_last,
                         i == 8 || i == 17, i == 0 || i == 9, i == 8 || i == 17);
            else passed++;
        end
        total++;
        if (gaps !== 0)
            $display("FAIL b2b_gaps got %0d invalid cycles want 0", gaps);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({ser_valid, busy, din_ready} !== 3'b001)
            $display("FAIL b2b_idle v/busy/rdy=%b%b%b want 001", ser_valid, busy, din_ready);
        else passed++;
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] w;
        int lasts;
        w = 8'h3C;
        lasts = 0;
        din = w; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (ser_last) lasts++;
            total++;
            if (ser_out !== w[i])
                $display("FAIL rst_pre_bit%0d ser_out=%b want %b", i, ser_out, w[i]);
            else passed++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ser_valid, ser_out, ser_first, ser_last, busy, din_ready} !== 6'b000001)
            $display("FAIL rst_async v/o/f/l/busy/rdy=%b%b%b%b%b%b want 000001",
                     ser_valid, ser_out, ser_first, ser_last, busy, din_ready);
        else passed++;
        repeat (2) begin
            @(posedge clk); #1;
            if (ser_last) lasts++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (ser_last) lasts++;
        total++;
        if (lasts !== 0 || din_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_after lasts=%0d rdy=%b busy=%b want 0 1 0", lasts, din_ready, busy);
        else passed++;
        test_single_frame(8'h81, 1'b0, "w81");
    endtask

    initial begin
        test_reset();
        test_single_frame(8'hA5, 1'b0, "wA5");
        test_checker_even();
        test_odd_parity();
        test_back_to_back();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
